frame_scanout: RTL and testbench
================================

// Module: frame_scanout
// PURPOSE
//  Read side of the double-buffered 1bpp frame buffer. Generates VGA-style raster timing, walks the
//  front buffer linearly via fb_rd_addr, and aligns returned fb_rd_data with hsync/vsync/de.
//  Issues the one-cycle fb_swap strobe during vertical blank, only once the renderer has
//  declared the back buffer complete. Sits between frame_buffer and the video PHY/encoder.
// PARAMETERS
//  H_ACTIVE  640  visible pixels/line        | H_FP 16 | H_SYNC 96 | H_BP 48   (H_TOTAL = sum = 800)
//  V_ACTIVE  480  visible lines/frame        | V_FP 10 | V_SYNC 2  | V_BP 33   (V_TOTAL = sum = 525)
//  SYNC_POL  0    active level of hsync/vsync (0 = active-low)
//  RD_LAT    1    frame buffer read latency in cycles (oce tied low -> 1)
//  ADDR_W    19   fb address width; elaboration error if H_ACTIVE*V_ACTIVE > 2**ADDR_W
// PORTS
//  clk          in   1       pixel clock (same clock as frame buffer rd_clk)
//  rst_n        in   1       asynchronous, active-low reset
//  ce           in   1       clock enable; low = all state frozen
//  fb_rd_addr   out  ADDR_W  read address to frame buffer
//  fb_rd_data   in   1       read data, valid RD_LAT cycles after fb_rd_addr
//  fb_swap      out  1       one-cycle buffer swap strobe
//  frame_ready  in   1       renderer pulse/level: back buffer complete
//  frame_tick   out  1       one-cycle pulse at start of every vertical blank
//  hsync, vsync out  1       sync outputs, polarity SYNC_POL
//  de           out  1       active video
//  pixel        out  1       pixel value; 0 whenever de = 0
// BEHAVIOUR
//  - Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps -> v increments; v wraps -> 0. Advance only when ce=1.
//  - Active = h<H_ACTIVE && v<V_ACTIVE. hsync active for h in [H_ACTIVE+H_FP, +H_SYNC); vsync same rule on v.
//  - Address: linear counter, no multiplier. Registered: fb_rd_addr holds address of counter pixel (h,v)
//    one cycle later. Increments by 1 per active cycle, resets to 0 at (h=0,v=0) edge; holds outside active.
//    Sequence: 0..639 line 0, 640.. line 1, last 307199.
//  - hsync/vsync/de delayed 1+RD_LAT registered stages so pixel = fb_rd_data aligns with de exactly.
//  - Swap: sticky pending bit set by frame_ready=1 (ce=1). At counter (h=0, v=V_ACTIVE): if pending or
//    frame_ready this same cycle -> fb_swap=1 for one cycle, pending cleared. Multiple frame_ready in one frame ->
//    single swap. frame_ready in the swap cycle counts for that swap, not the next. No swap outside that point.
//  - frame_tick = 1 at (h=0, v=V_ACTIVE) every frame, independent of swap.
//  - ce=0: counters, pipeline, pending hold; fb_swap and frame_tick forced 0; other outputs hold.
//  - Reset (any time, incl. mid-line): h=v=0, fb_rd_addr=0, pending=0, fb_swap=0, frame_tick=0, de=0,
//    pixel=0, hsync=vsync=~SYNC_POL. First cycle after release starts pixel (0,0).
// CONFIGURATION
//  `define SCANOUT_BORDER_EN : pixel forced 1 for delayed active pixels with h in {0,H_ACTIVE-1} or
//    v in {0,V_ACTIVE-1} (panel alignment aid); border flags pipelined with de.
//  Undefined: pixel = de ? fb_rd_data : 0. Timing/address/swap identical in both builds.
// STRUCTURE
//  Package video_pkg: default 640x480 timing localparams, FB_ADDR_W=19, typedef logic [FB_ADDR_W-1:0] fb_addr_t;
//    shared with renderer and frame_buffer wrapper.
//  Sub-module video_timing_gen: h/v counters, active/hsync/vsync/frame-edge flags. frame_scanout adds
//    address counter, RD_LAT alignment pipeline, swap arbitration, optional border.
// TESTING  (bench memory model: 1-cycle latency, data = addr[0]^addr[10])
//  - Release reset, run 420000 cycles -> line period 800, hsync active 96 cycles per line, 525 lines, vsync 2 lines.
//  - Address check -> addr 0 at first active, 640 at line 1 start, 307199 last; pixel == model(addr) when de=1.
//  - frame_ready pulse at v=100 -> exactly one fb_swap at (h=0,v=480); no fb_swap next frame.
//  - frame_ready at v=10 and v=300 same frame -> one swap; frame_ready exactly at swap cycle -> swap that cycle.
//  - ce=0 for 100 cycles mid-line -> outputs frozen; frame length becomes 420100 cycles; no strobes lost/duplicated.
//  - rst_n low mid-line with pending set -> outputs at reset values immediately, pending cleared, no swap;
//    SCANOUT_BORDER_EN build: pixel=1 on edge rows/cols with model data forced 0.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - Shared 640x480 video timing constants and frame buffer types
package video_pkg;

    localparam int VID_H_ACTIVE = 640;
    localparam int VID_H_FP     = 16;
    localparam int VID_H_SYNC   = 96;
    localparam int VID_H_BP     = 48;
    localparam int VID_V_ACTIVE = 480;
    localparam int VID_V_FP     = 10;
    localparam int VID_V_SYNC   = 2;
    localparam int VID_V_BP     = 33;

    localparam int FB_ADDR_W    = 19;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    // Per-pixel flags that travel down the read-latency alignment pipeline
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic border;
    } pix_flags_t;

    typedef struct packed {
        pix_flags_t pix;
        logic       frame_start;
        logic       frame_edge;
    } timing_t;

endpackage

// File: rtl/frame_scanout_if.sv
// rtl/frame_scanout_if.sv - Frame buffer read port and buffer-swap handshake
interface frame_scanout_if
    import video_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
);
    logic [ADDR_W-1:0] fb_rd_addr;
    logic              fb_rd_data;
    logic              fb_swap;
    logic              frame_ready;

    modport master (
        output fb_rd_addr,
        output fb_swap,
        input  fb_rd_data,
        input  frame_ready
    );

    modport slave (
        input  fb_rd_addr,
        input  fb_swap,
        output fb_rd_data,
        output frame_ready
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - Raster h/v counters and per-pixel timing flags
// Border flag is only generated when SCANOUT_BORDER_EN is defined.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_FP     = VID_H_FP,
    parameter int H_SYNC   = VID_H_SYNC,
    parameter int H_BP     = VID_H_BP,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_FP     = VID_V_FP,
    parameter int V_SYNC   = VID_V_SYNC,
    parameter int V_BP     = VID_V_BP
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ce,
    output timing_t timing
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_ACT_L  = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_L  = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        timing           = '0;
        timing.pix.de    = (h < H_ACT) && (v < V_ACT);
        timing.pix.hsync = (h >= HS_BEG) && (h < HS_END);
        timing.pix.vsync = (v >= VS_BEG) && (v < VS_END);
`ifdef SCANOUT_BORDER_EN
        timing.pix.border = timing.pix.de &&
                            ((h == '0) || (h == H_ACT_L) || (v == '0) || (v == V_ACT_L));
`else
        timing.pix.border = 1'b0;
`endif
        timing.frame_start = (h == '0) && (v == '0);
        // First blanking line: where the buffer swap and frame tick happen
        timing.frame_edge  = (h == '0) && (v == V_ACT);
    end

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - Frame buffer scanout: address walk, latency alignment, swap arbitration
// Optional SCANOUT_BORDER_EN edge-pixel overlay is generated in video_timing_gen.
module frame_scanout
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = VID_H_ACTIVE,
    parameter int   H_FP     = VID_H_FP,
    parameter int   H_SYNC   = VID_H_SYNC,
    parameter int   H_BP     = VID_H_BP,
    parameter int   V_ACTIVE = VID_V_ACTIVE,
    parameter int   V_FP     = VID_V_FP,
    parameter int   V_SYNC   = VID_V_SYNC,
    parameter int   V_BP     = VID_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   RD_LAT   = 1,
    parameter int   ADDR_W   = FB_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    frame_scanout_if.master fb,
    output logic            frame_tick,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            pixel
);
    localparam int DLY = 1 + RD_LAT;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    if (H_ACTIVE * V_ACTIVE > 2 ** ADDR_W) begin : g_addr_check
        $error("frame_scanout: ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
    end

    timing_t           tm;
    logic [ADDR_W-1:0] rd_addr;
    logic              pending;
    pix_flags_t        pipe [DLY];
    pix_flags_t        out_flags;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .timing (tm)
    );

    // Linear address: restart at top-left, step on active pixels, hold in blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (ce) begin
            if (tm.frame_start) begin
                rd_addr <= '0;
            end else if (tm.pix.de) begin
                rd_addr <= rd_addr + ADDR_ONE;
            end
        end
    end

    assign fb.fb_rd_addr = rd_addr;

    // One stage for the address register plus RD_LAT stages for the memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= tm.pix;
            for (int i = 1; i < DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_flags = pipe[DLY-1];
    assign de        = out_flags.de;
    assign hsync     = out_flags.hsync ? SYNC_POL : ~SYNC_POL;
    assign vsync     = out_flags.vsync ? SYNC_POL : ~SYNC_POL;
    assign pixel     = out_flags.de & (fb.fb_rd_data | out_flags.border);

    // A ready seen on the swap cycle itself is consumed by that swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (ce) begin
            if (tm.frame_edge) begin
                pending <= 1'b0;
            end else if (fb.frame_ready) begin
                pending <= 1'b1;
            end
        end
    end

    assign fb.fb_swap = ce & tm.frame_edge & (pending | fb.frame_ready);
    assign frame_tick = ce & tm.frame_edge;

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - Self-checking bench for frame_scanout against a position-based raster model
module tb_frame_scanout;

    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 3;
    localparam int HBP   = 3;
    localparam int VA    = 12;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic clk;
    logic rst_n;
    logic ce;
    logic frame_tick;
    logic hsync;
    logic vsync;
    logic de;
    logic pixel;

    frame_scanout_if #(.ADDR_W(19)) fbi ();

    frame_scanout #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .SYNC_POL (1'b0),
        .RD_LAT   (1),
        .ADDR_W   (19)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .fb         (fbi),
        .frame_tick (frame_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .pixel      (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int p = 0;
    int cyc = 0;
    int last_ready = -1;
    int last_edge = -1;
    int last_tick_cyc = 0;
    int tick_gap = 0;
    int swaps = 0;
    int s0 = 0;

    function automatic int ph(input int q);
        return q % HT;
    endfunction

    function automatic int pv(input int q);
        return (q / HT) % VT;
    endfunction

    function automatic bit is_act(input int q);
        return (q >= 0) && (ph(q) < HA) && (pv(q) < VA);
    endfunction

    function automatic bit in_hs(input int q);
        return (q >= 0) && (ph(q) >= HA + HFP) && (ph(q) < HA + HFP + HS);
    endfunction

    function automatic bit in_vs(input int q);
        return (q >= 0) && (pv(q) >= VA + VFP) && (pv(q) < VA + VFP + VS);
    endfunction

    function automatic int addr_of(input int q);
        if (q < 0) return 0;
        if (pv(q) >= VA) return HA * VA - 1;
        if (ph(q) >= HA) return pv(q) * HA + HA - 1;
        return pv(q) * HA + ph(q);
    endfunction

    function automatic bit mem_data(input int a);
        return bit'(((a & 1) ^ ((a >> 10) & 1)) != 0);
    endfunction

    function automatic bit is_border(input int q);
`ifdef SCANOUT_BORDER_EN
        return is_act(q) && (ph(q) == 0 || ph(q) == HA - 1 || pv(q) == 0 || pv(q) == VA - 1);
`else
        return (q < -1);
`endif
    endfunction

    function automatic bit exp_pixel(input int q);
        if (!is_act(q)) return 1'b0;
        return mem_data(addr_of(q)) | is_border(q);
    endfunction

    // Frame buffer with one cycle of read latency, read enable tied to ce
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fbi.fb_rd_data <= 1'b0;
        else if (ce) fbi.fb_rd_data <= mem_data(int'(fbi.fb_rd_addr));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic ce_v, input logic fr_v);
        bit tick_e;
        bit swap_e;
        ce = ce_v;
        fbi.frame_ready = fr_v;
        #1;
        if (ce_v && fr_v) last_ready = p;
        tick_e = ce_v && (ph(p) == 0) && (pv(p) == VA);
        swap_e = tick_e && (last_ready > last_edge);
        chk("de", de, is_act(p - 2));
        chk("hsync", hsync, !in_hs(p - 2));
        chk("vsync", vsync, !in_vs(p - 2));
        chk("pixel", pixel, exp_pixel(p - 2));
        chk("addr", fbi.fb_rd_addr, addr_of(p - 1));
        chk("tick", frame_tick, tick_e);
        chk("swap", fbi.fb_swap, swap_e);
        if (frame_tick === 1'b1) begin
            tick_gap = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
        end
        if (fbi.fb_swap === 1'b1) swaps++;
        if (tick_e) last_edge = p;
        @(posedge clk);
        if (ce_v) p++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic go_to(input int th, input int tv);
        for (int n = 0; n < FRAME && !(ph(p) == th && pv(p) == tv); n++) step(1'b1, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_pixel"}, pixel, 0);
        chk({tag, "_addr"}, fbi.fb_rd_addr, 0);
        chk({tag, "_tick"}, frame_tick, 0);
        chk({tag, "_swap"}, fbi.fb_swap, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b0;
        fbi.frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ce = 1'b1;
        fbi.frame_ready = 1'b1;
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Idle frames: raster timing, no swaps
        repeat (2 * FRAME) step(1'b1, 1'b0);
        chk("idle_swaps", swaps, 0);
        chk("frame_len", tick_gap, FRAME);

        go_to(1, 1);
        chk("addr_line1", fbi.fb_rd_addr, HA);
        go_to(0, VA);
        chk("addr_last", fbi.fb_rd_addr, HA * VA - 1);

        // Single ready pulse mid-frame
        s0 = swaps;
        go_to(3, 5);
        step(1'b1, 1'b1);
        go_to(0, VA);
        step(1'b1, 1'b0);
        chk("single_swap", swaps - s0, 1);
        repeat (FRAME) step(1'b1, 1'b0);
        chk("no_repeat_swap", swaps - s0, 1);

        // Two readies in one frame collapse into one swap
        s0 = swaps;
        go_to(2, 1);
        step(1'b1, 1'b1);
        go_to(5, 8);
        step(1'b1, 1'b1);
        go_to(0, VA);
        step(1'b1, 1'b0);
        chk("two_ready_one_swap", swaps - s0, 1);

        // Ready exactly on the swap cycle
        s0 = swaps;
        go_to(0, VA);
        step(1'b1, 1'b1);
        chk("ready_at_edge", swaps - s0, 1);

        // Ready held across the edge: swap now, and the post-edge cycle arms the next one
        s0 = swaps;
        go_to(HT - 2, VA - 1);
        repeat (4) step(1'b1, 1'b1);
        go_to(0, VA);
        step(1'b1, 1'b0);
        chk("ready_straddle", swaps - s0, 2);

        // Clock-enable stall mid-line; ready while stalled is ignored
        go_to(0, VA);
        step(1'b1, 1'b0);
        s0 = swaps;
        go_to(7, 3);
        repeat (100) step(1'b0, 1'b1);
        go_to(0, VA);
        step(1'b1, 1'b0);
        chk("stall_frame_len", tick_gap, FRAME + 100);
        chk("stall_swaps", swaps - s0, 0);

        // Random ce and frame_ready
        repeat (1500) step(($urandom_range(0, 4) != 0), ($urandom_range(0, 59) == 0));

        // Reset mid-line with a swap pending
        go_to(4, 6);
        step(1'b1, 1'b1);
        go_to(9, 7);
        rst_n = 1'b0;
        ce = 1'b1;
        fbi.frame_ready = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_hold");
        rst_n = 1'b1;
        p = 0;
        last_ready = -1;
        last_edge = -1;
        s0 = swaps;
        repeat (FRAME + 5) step(1'b1, 1'b0);
        chk("rst_no_swap", swaps - s0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
